// File: rtl/conjunto_reg_param.sv
// Parametrised register file: one write port, N_READ combinational read ports with
// write-first bypass, optional hardwired-zero x0, and a one-register-per-cycle clear sweep.
module conjunto_reg_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_en,
    input  logic [$clog2(NREG)-1:0]    write_addr,
    input  logic [XLEN-1:0]            write_data,
    input  logic [N_READ*$clog2(NREG)-1:0] addr,
    output logic [N_READ*XLEN-1:0]     datos,
    input  logic                       clear_req,
    output logic                       busy
);

    localparam int AW = $clog2(NREG);

    // Handshake: busy=1 means the clear sweep owns the array; write_en is dropped
    // (not queued) while busy, so the caller must hold off until busy=0.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clear_ptr_q, clear_ptr_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_fire;
    logic            wr_store;
    logic            bypass_ok;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        regs_d      = regs_q;
        wr_fire     = write_en && (state_q == IDLE);
        wr_store    = wr_fire && !((ZERO_REG != 0) && (write_addr == '0));

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d     = CLEAR;
                    clear_ptr_d = '0;
                end
            end
            CLEAR: begin
                regs_d[clear_ptr_q] = '0;
                clear_ptr_d         = clear_ptr_q + 1'b1;
                if (clear_ptr_q == AW'(NREG - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes only fire in IDLE, so they never collide with the sweep.
        if (wr_store) begin
            regs_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clear_ptr_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            regs_q      <= regs_d;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign bypass_ok = write_en && (state_q == IDLE) && rst_n;

    for (genvar g = 0; g < N_READ; g++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;

        assign rd_addr = addr[g*AW +: AW];

        // Hardwired zero wins over the bypass; the bypass wins over storage.
        always_comb begin
            rd_data = regs_q[rd_addr];
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_data = '0;
            end else if (bypass_ok && (rd_addr == write_addr)) begin
                rd_data = write_data;
            end
        end

        assign datos[g*XLEN +: XLEN] = rd_data;
    end

endmodule

// File: tb/tb_conjunto_reg_param.sv
// Bench for conjunto_reg_param: a default 32x32/2-port instance and a 16-bit 8x3-port
// instance without a zero register, checked through an expected-value queue.
`timescale 1ns/100ps
module tb_conjunto_reg_param;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (defaults) ----------------
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [9:0]  addr_a;
    logic [63:0] datos_a;
    logic        clr_a;
    logic        busy_a;

    conjunto_reg_param dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (we_a),
        .write_addr (wa_a),
        .write_data (wd_a),
        .addr       (addr_a),
        .datos      (datos_a),
        .clear_req  (clr_a),
        .busy       (busy_a)
    );

    // ---------------- DUT B (16-bit, 8 regs, 3 ports, no zero reg) ----------------
    logic        we_b;
    logic [2:0]  wa_b;
    logic [15:0] wd_b;
    logic [8:0]  addr_b;
    logic [47:0] datos_b;
    logic        clr_b;
    logic        busy_b;

    conjunto_reg_param #(
        .XLEN     (16),
        .NREG     (8),
        .N_READ   (3),
        .ZERO_REG (0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (we_b),
        .write_addr (wa_b),
        .write_data (wd_b),
        .addr       (addr_b),
        .datos      (datos_b),
        .clear_req  (clr_b),
        .busy       (busy_b)
    );

    // ---------------- scoreboard ----------------
    // kind: 0 datos_a, 1 busy_a, 2 datos_b, 3 busy_b, 4 bench-measured value in act_q
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        chk_stb = 1'b0;

    task automatic chk(input int kind, input logic [63:0] exp, input string nm,
                       input logic [63:0] act);
        #0.5;
        exp_q.push_back(exp);
        act_q.push_back(act);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        chk_stb = 1'b1;
        #0.5;
        chk_stb = 1'b0;
    endtask

    always @(posedge chk_stb) begin : monitor
        logic [63:0] e;
        logic [63:0] a;
        logic [63:0] m;
        int          k;
        string       nm;
        e  = exp_q.pop_front();
        m  = act_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        case (k)
            0:       a = datos_a;
            1:       a = {63'b0, busy_a};
            2:       a = {16'b0, datos_b};
            3:       a = {63'b0, busy_b};
            default: a = m;
        endcase
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc_a(input logic we, input int wa, input logic [31:0] wd,
                         input int a1, input int a0);
        @(negedge clk);
        we_a   = we;
        wa_a   = wa[4:0];
        wd_a   = wd;
        addr_a = {a1[4:0], a0[4:0]};
        clr_a  = 1'b0;
    endtask

    task automatic cyc_b(input logic we, input int wa, input logic [15:0] wd,
                         input int a2, input int a1, input int a0);
        @(negedge clk);
        we_b   = we;
        wa_b   = wa[2:0];
        wd_b   = wd;
        addr_b = {a2[2:0], a1[2:0], a0[2:0]};
        clr_b  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic [31:0] ev;

        rst_n = 1'b0;
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hAAAA_AAAA; addr_a = {5'd3, 5'd3}; clr_a = 1'b0;
        we_b = 1'b0; wa_b = '0; wd_b = '0; addr_b = '0; clr_b = 1'b0;
        #1;
        chk(0, 64'h0, "reset_datos_no_bypass", 64'h0);
        chk(1, 64'h0, "reset_busy", 64'h0);
        chk(2, 64'h0, "reset_datos_b", 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        we_a  = 1'b0;

        // hardwired zero
        cyc_a(1'b1, 0, 32'h1234_5678, 0, 0);
        chk(0, 64'h0, "x0_write_cycle", 64'h0);
        cyc_a(1'b0, 0, 32'h0, 0, 0);
        chk(0, 64'h0, "x0_after_write", 64'h0);

        // write / read back
        cyc_a(1'b1, 1, 32'hDEAD_BEEF, 0, 0);
        cyc_a(1'b1, 2, 32'h1234_5678, 0, 0);
        cyc_a(1'b0, 0, 32'h0, 2, 1);
        chk(0, {32'h1234_5678, 32'hDEAD_BEEF}, "readback_2_1", 64'h0);

        // bypass
        cyc_a(1'b1, 5, 32'h1111_1111, 0, 0);
        cyc_a(1'b0, 0, 32'h0, 5, 5);
        chk(0, {32'h1111_1111, 32'h1111_1111}, "x5_old", 64'h0);
        cyc_a(1'b1, 5, 32'hCAFE_F00D, 5, 5);
        chk(0, {32'hCAFE_F00D, 32'hCAFE_F00D}, "bypass_both", 64'h0);
        addr_a = {5'd1, 5'd5};
        chk(0, {32'hDEAD_BEEF, 32'hCAFE_F00D}, "bypass_lane0_only", 64'h0);
        cyc_a(1'b0, 0, 32'h0, 5, 5);
        chk(0, {32'hCAFE_F00D, 32'hCAFE_F00D}, "x5_stored", 64'h0);

        // fill x1..x31 with their index, then sweep
        for (int i = 1; i < 32; i++) cyc_a(1'b1, i, 32'(i), 0, 0);
        cyc_a(1'b0, 0, 32'h0, 10, 3);
        clr_a = 1'b1;
        chk(0, {32'd10, 32'd3}, "pre_clear", 64'h0);
        chk(1, 64'h0, "busy_before_edge", 64'h0);
        cyc = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            clr_a = 1'b0;
            we_a  = 1'b0;
            if (!busy_a) break;
            cyc++;
            if (cyc == 6) begin
                addr_a = {5'd10, 5'd3};
                chk(0, {32'd10, 32'd0}, "mid_sweep", 64'h0);
            end
            if (cyc == 8) begin
                we_a = 1'b1; wa_a = 5'd20; wd_a = 32'hFFFF_FFFF; addr_a = {5'd20, 5'd20};
                chk(0, {32'd20, 32'd20}, "busy_no_bypass", 64'h0);
            end
            if (cyc == 12) clr_a = 1'b1;
        end
        chk(4, 64'd32, "busy_cycles", 64'(cyc));
        // first write accepted on the edge that sees busy=0
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h77; addr_a = {5'd7, 5'd20};
        chk(0, {32'h77, 32'h0}, "first_write_bypass", 64'h0);
        for (int i = 0; i < 32; i += 2) begin
            cyc_a(1'b0, 0, 32'h0, i + 1, i);
            ev = (i + 1 == 7) ? 32'h77 : 32'h0;
            chk(0, {ev, 32'h0}, $sformatf("cleared_x%0d_x%0d", i + 1, i), 64'h0);
        end

        // reset in the middle of a sweep
        cyc_a(1'b1, 9, 32'd99, 0, 0);
        cyc_a(1'b0, 0, 32'h0, 9, 9);
        chk(0, {32'd99, 32'd99}, "x9_pre", 64'h0);
        clr_a = 1'b1;
        cyc = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            clr_a = 1'b0;
            if (busy_a) cyc++;
            if (cyc == 7) begin
                rst_n  = 1'b0;
                addr_a = {5'd9, 5'd9};
                chk(1, 64'h0, "rst_busy", 64'h0);
                chk(0, 64'h0, "rst_datos", 64'h0);
                break;
            end
        end
        chk(4, 64'd7, "rst_point", 64'(cyc));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(1, 64'h0, "no_residual_clear", 64'h0);
        cyc_a(1'b1, 4, 32'd1, 0, 0);
        cyc_a(1'b0, 0, 32'h0, 4, 4);
        chk(0, {32'd1, 32'd1}, "x4_after_rst", 64'h0);
        chk(1, 64'h0, "busy_after_rst", 64'h0);

        // parametrised instance: x0 writable, 3 lanes, 8-cycle clear
        cyc_b(1'b1, 0, 16'hBEEF, 0, 0, 0);
        chk(2, {16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF}, "b_x0_bypass", 64'h0);
        cyc_b(1'b1, 3, 16'h1234, 3, 0, 3);
        chk(2, {16'h0, 16'h1234, 16'hBEEF, 16'h1234}, "b_bypass", 64'h0);
        cyc_b(1'b0, 0, 16'h0, 0, 0, 0);
        chk(2, {16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF}, "b_x0_stored", 64'h0);
        clr_b = 1'b1;
        cyc = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            clr_b = 1'b0;
            if (!busy_b) break;
            cyc++;
        end
        chk(4, 64'd8, "b_busy_cycles", 64'(cyc));
        addr_b = {3'd0, 3'd3, 3'd0};
        chk(2, 64'h0, "b_after_clear", 64'h0);

        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
